// File: rtl/quad_operand_gather.sv
// Quad-precision operand gather: collects up to three 4-word operands through one
// synchronous register-file read port and hands them to the 128-bit ALU stage.
module quad_operand_gather #(
    parameter int  RW            = 6,
    parameter type instruction_t = logic [31:0]
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          flush,
    input  logic          in_valid,
    output logic          in_ready,
    input  instruction_t  in_ir,
    input  logic [RW-1:0] in_ra,
    input  logic [RW-1:0] in_rb,
    input  logic [RW-1:0] in_rc,
    input  logic [2:0]    in_mask,
    output logic          rf_re,
    output logic [RW-1:0] rf_ra,
    input  logic [31:0]   rf_rd,
    output logic          o_valid,
    input  logic          o_ready,
    output instruction_t  o_ir,
    output logic [127:0]  o_a,
    output logic [127:0]  o_b,
    output logic [127:0]  o_c
);

    typedef enum logic [1:0] {IDLE, READ, DRAIN, DONE} state_t;

    state_t        r_state;
    state_t        w_state_nxt;
    instruction_t  r_ir;
    logic [2:0]    r_mask;
    logic [RW-1:0] r_base_a;
    logic [RW-1:0] r_base_b;
    logic [RW-1:0] r_base_c;
    logic [1:0]    r_op;
    logic [1:0]    r_word;
    logic          r_tag_vld;
    logic [1:0]    r_tag_op;
    logic [1:0]    r_tag_word;
    logic [RW-1:0] r_ra_hold;
    logic          r_o_valid;
    logic [127:0]  r_a;
    logic [127:0]  r_b;
    logic [127:0]  r_c;

    logic          w_accept;
    logic          w_flush;
    logic          w_last;
    logic [2:0]    w_first;
    logic [2:0]    w_next;
    logic [RW-1:0] w_base;
    logic [RW-1:0] w_addr;

    // Returns {found, index} of the lowest set mask bit at or above start.
    function automatic logic [2:0] find_op(input logic [2:0] mask, input logic [1:0] start);
        logic [2:0] res;
        res = 3'b000;
        for (int i = 2; i >= 0; i--) begin
            if (i >= int'(start) && mask[i]) res = {1'b1, 2'(i)};
        end
        return res;
    endfunction

    always_comb begin
        w_state_nxt = r_state;
        w_accept    = 1'b0;
        w_flush     = flush && (r_state != IDLE);
        w_first     = find_op(in_mask, 2'd0);
        w_next      = find_op(r_mask, r_op + 2'd1);
        w_last      = (r_word == 2'd3) && !w_next[2];
        case (r_op)
            2'd1:    w_base = r_base_b;
            2'd2:    w_base = r_base_c;
            default: w_base = r_base_a;
        endcase
        w_addr   = w_base + RW'(r_word);
        in_ready = (r_state == IDLE);
        rf_re    = (r_state == READ);
        rf_ra    = rf_re ? w_addr : r_ra_hold;
        case (r_state)
            IDLE: begin
                if (in_valid && !flush) begin
                    w_accept    = 1'b1;
                    w_state_nxt = (in_mask != 3'b000) ? READ : DRAIN;
                end
            end
            READ:    if (w_last) w_state_nxt = DRAIN;
            DRAIN:   w_state_nxt = DONE;
            DONE:    if (o_ready) w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
        if (w_flush) w_state_nxt = IDLE;
    end

    always_ff @(posedge clk) begin
        if (rst) r_state <= IDLE;
        else     r_state <= w_state_nxt;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_ir       <= '0;
            r_mask     <= 3'b000;
            r_base_a   <= '0;
            r_base_b   <= '0;
            r_base_c   <= '0;
            r_op       <= 2'd0;
            r_word     <= 2'd0;
            r_tag_vld  <= 1'b0;
            r_tag_op   <= 2'd0;
            r_tag_word <= 2'd0;
            r_ra_hold  <= '0;
            r_o_valid  <= 1'b0;
            r_a        <= '0;
            r_b        <= '0;
            r_c        <= '0;
        end else if (w_flush) begin
            r_tag_vld <= 1'b0;
            r_o_valid <= 1'b0;
            r_a       <= '0;
            r_b       <= '0;
            r_c       <= '0;
        end else begin
            r_tag_vld <= rf_re;
            if (w_accept) begin
                r_ir     <= in_ir;
                r_mask   <= in_mask;
                r_base_a <= in_ra & ~RW'(3);
                r_base_b <= in_rb & ~RW'(3);
                r_base_c <= in_rc & ~RW'(3);
                r_op     <= w_first[1:0];
                r_word   <= 2'd0;
                r_a      <= '0;
                r_b      <= '0;
                r_c      <= '0;
            end
            // Read stage: issue address and remember its (operand, word) tag.
            if (rf_re) begin
                r_tag_op   <= r_op;
                r_tag_word <= r_word;
                r_ra_hold  <= w_addr;
                if (r_word == 2'd3) begin
                    r_word <= 2'd0;
                    r_op   <= w_next[1:0];
                end else begin
                    r_word <= r_word + 2'd1;
                end
            end
            // Capture stage: read data arrives one cycle after its address.
            if (r_tag_vld) begin
                case (r_tag_op)
                    2'd1:    r_b[{r_tag_word, 5'd0} +: 32] <= rf_rd;
                    2'd2:    r_c[{r_tag_word, 5'd0} +: 32] <= rf_rd;
                    default: r_a[{r_tag_word, 5'd0} +: 32] <= rf_rd;
                endcase
            end
            if (r_state == DRAIN)                r_o_valid <= 1'b1;
            else if (r_state == DONE && o_ready) r_o_valid <= 1'b0;
        end
    end

    assign o_valid = r_o_valid;
    assign o_ir    = r_ir;
    assign o_a     = r_a;
    assign o_b     = r_b;
    assign o_c     = r_c;

endmodule

// File: tb/tb_quad_operand_gather.sv
// Scoreboard bench for quad_operand_gather: directed gathers, output stall,
// flush and mid-gather reset, with a register file whose word r holds 0x1000_0000+r.
module tb_quad_operand_gather;

    localparam int RW = 6;

    typedef struct {
        logic [31:0]  ir;
        logic [127:0] a;
        logic [127:0] b;
        logic [127:0] c;
    } exp_t;

    logic          clk;
    logic          rst;
    logic          flush;
    logic          in_valid;
    logic          in_ready;
    logic [31:0]   in_ir;
    logic [RW-1:0] in_ra;
    logic [RW-1:0] in_rb;
    logic [RW-1:0] in_rc;
    logic [2:0]    in_mask;
    logic          rf_re;
    logic [RW-1:0] rf_ra;
    logic [31:0]   rf_rd;
    logic          o_valid;
    logic          o_ready;
    logic [31:0]   o_ir;
    logic [127:0]  o_a;
    logic [127:0]  o_b;
    logic [127:0]  o_c;

    exp_t sb[$];
    int   n_checks;
    int   n_fail;

    quad_operand_gather #(.RW(RW)) dut (
        .clk      (clk),
        .rst      (rst),
        .flush    (flush),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_ir    (in_ir),
        .in_ra    (in_ra),
        .in_rb    (in_rb),
        .in_rc    (in_rc),
        .in_mask  (in_mask),
        .rf_re    (rf_re),
        .rf_ra    (rf_ra),
        .rf_rd    (rf_rd),
        .o_valid  (o_valid),
        .o_ready  (o_ready),
        .o_ir     (o_ir),
        .o_a      (o_a),
        .o_b      (o_b),
        .o_c      (o_c)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Register file: synchronous read, garbage on the data bus when not reading.
    always @(posedge clk) begin
        if (rf_re) rf_rd <= 32'h1000_0000 + 32'(rf_ra);
        else       rf_rd <= $urandom;
    end

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %h required %h", nm, act, req);
        end
    endtask

    // Monitor: every accepted output is popped and compared.
    always @(negedge clk) begin
        if (!rst && o_valid && o_ready && !flush) begin
            if (sb.size() == 0) begin
                chk("sb_unexpected_valid", 128'(o_valid), 128'(0));
            end else begin
                exp_t e;
                e = sb.pop_front();
                chk("sb_ir", 128'(o_ir), 128'(e.ir));
                chk("sb_a", o_a, e.a);
                chk("sb_b", o_b, e.b);
                chk("sb_c", o_c, e.c);
            end
        end
    end

    task automatic chk_reset_vals();
        chk("rst_in_ready", 128'(in_ready), 128'(1));
        chk("rst_rf_re", 128'(rf_re), 128'(0));
        chk("rst_rf_ra", 128'(rf_ra), 128'(0));
        chk("rst_o_valid", 128'(o_valid), 128'(0));
        chk("rst_o_ir", 128'(o_ir), 128'(0));
        chk("rst_o_a", o_a, 128'(0));
        chk("rst_o_b", o_b, 128'(0));
        chk("rst_o_c", o_c, 128'(0));
    endtask

    // Starts and ends at a falling edge with the DUT idle.
    task automatic gather(input logic [31:0] ir, input logic [RW-1:0] ra, input logic [RW-1:0] rb,
                          input logic [RW-1:0] rc, input logic [2:0] mask, input logic [127:0] ea,
                          input logic [127:0] eb, input logic [127:0] ec, input int hold);
        exp_t          e;
        logic [RW-1:0] base[3];
        logic [RW-1:0] addrs[$];
        base[0] = {ra[RW-1:2], 2'b00};
        base[1] = {rb[RW-1:2], 2'b00};
        base[2] = {rc[RW-1:2], 2'b00};
        for (int op = 0; op < 3; op++)
            if (mask[op]) for (int k = 0; k < 4; k++) addrs.push_back(base[op] + RW'(k));
        e.ir = ir; e.a = ea; e.b = eb; e.c = ec;
        in_ir = ir; in_ra = ra; in_rb = rb; in_rc = rc; in_mask = mask;
        in_valid = 1'b1;
        o_ready = (hold == 0);
        chk("c0_in_ready", 128'(in_ready), 128'(1));
        sb.push_back(e);
        @(posedge clk); #1;
        in_valid = 1'b0;
        for (int i = 0; i < addrs.size(); i++) begin
            @(negedge clk);
            chk("read_rf_re", 128'(rf_re), 128'(1));
            chk("read_rf_ra", 128'(rf_ra), 128'(addrs[i]));
            chk("read_in_ready", 128'(in_ready), 128'(0));
            @(posedge clk); #1;
        end
        @(negedge clk);
        chk("drain_rf_re", 128'(rf_re), 128'(0));
        chk("drain_o_valid", 128'(o_valid), 128'(0));
        @(posedge clk); #1;
        for (int h = 0; h < hold; h++) begin
            in_valid = (h % 2 == 0);
            @(negedge clk);
            chk("stall_o_valid", 128'(o_valid), 128'(1));
            chk("stall_in_ready", 128'(in_ready), 128'(0));
            chk("stall_rf_re", 128'(rf_re), 128'(0));
            chk("stall_o_a", o_a, ea);
            chk("stall_o_ir", 128'(o_ir), 128'(ir));
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        o_ready = 1'b1;
        @(negedge clk);
        chk("done_o_valid", 128'(o_valid), 128'(1));
        @(posedge clk); #1;
        @(negedge clk);
        chk("after_o_valid", 128'(o_valid), 128'(0));
        chk("after_in_ready", 128'(in_ready), 128'(1));
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        n_checks = 0; n_fail = 0;
        rst = 1'b1; flush = 1'b0; in_valid = 1'b0; o_ready = 1'b1;
        in_ir = '0; in_ra = '0; in_rb = '0; in_rc = '0; in_mask = '0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk_reset_vals();

        gather(32'h0000_00A1, 6'd8, 6'd12, 6'd0, 3'b011,
               128'h1000000B_1000000A_10000009_10000008,
               128'h1000000F_1000000E_1000000D_1000000C, 128'h0, 0);
        gather(32'h0000_00A2, 6'd0, 6'd0, 6'd7, 3'b100, 128'h0, 128'h0,
               128'h10000007_10000006_10000005_10000004, 0);
        gather(32'h0000_00A3, 6'd5, 6'd9, 6'd13, 3'b000, 128'h0, 128'h0, 128'h0, 0);
        gather(32'h0000_00A4, 6'd33, 6'd0, 6'd0, 3'b001,
               128'h10000023_10000022_10000021_10000020, 128'h0, 128'h0, 5);

        // Flush in cycle 3 of a three-operand gather.
        in_ir = 32'h0000_00B5; in_ra = 6'd0; in_rb = 6'd4; in_rc = 6'd8; in_mask = 3'b111;
        in_valid = 1'b1;
        @(posedge clk); #1 in_valid = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1 flush = 1'b1;
        @(negedge clk);
        chk("flush_c3_rf_re", 128'(rf_re), 128'(1));
        @(posedge clk); #1 flush = 1'b0;
        @(negedge clk);
        chk("flush_in_ready", 128'(in_ready), 128'(1));
        chk("flush_rf_re", 128'(rf_re), 128'(0));
        chk("flush_o_valid", 128'(o_valid), 128'(0));
        chk("flush_o_a", o_a, 128'(0));
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            chk("flush_quiet_o_valid", 128'(o_valid), 128'(0));
        end

        // Flush while idle blocks the accept.
        in_mask = 3'b001; in_ra = 6'd16; in_valid = 1'b1; flush = 1'b1;
        @(posedge clk); #1 in_valid = 1'b0; flush = 1'b0;
        @(negedge clk);
        chk("idle_flush_in_ready", 128'(in_ready), 128'(1));
        chk("idle_flush_rf_re", 128'(rf_re), 128'(0));
        gather(32'h0000_00B6, 6'd16, 6'd0, 6'd0, 3'b001,
               128'h10000013_10000012_10000011_10000010, 128'h0, 128'h0, 0);

        // Reset in cycle 4 of a gather.
        in_ir = 32'h0000_00C0; in_ra = 6'd20; in_rb = 6'd24; in_rc = 6'd0; in_mask = 3'b011;
        in_valid = 1'b1;
        @(posedge clk); #1 in_valid = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        @(posedge clk); #1 rst = 1'b1;
        @(posedge clk); #1 rst = 1'b0;
        @(negedge clk);
        chk_reset_vals();
        gather(32'h0000_00C1, 6'd20, 6'd24, 6'd0, 3'b011,
               128'h10000017_10000016_10000015_10000014,
               128'h1000001B_1000001A_10000019_10000018, 128'h0, 0);
        gather(32'h0000_00C2, 6'd40, 6'd45, 6'd50, 3'b111,
               128'h1000002B_1000002A_10000029_10000028,
               128'h1000002F_1000002E_1000002D_1000002C,
               128'h10000033_10000032_10000031_10000030, 0);

        @(negedge clk);
        chk("sb_empty", 128'(sb.size()), 128'(0));
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
